// File: rtl/stream_demux.sv
// stream_demux: valid/ready demultiplexer steering one input stream to N_OUT lanes
// through a small FIFO; a stalled head blocks later beats (strict order).
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_data/in_sel producer side;
// out_valid[N_OUT]/out_ready[N_OUT]/out_data lane side; drop_cnt counts bad-select beats.
// Option: STREAM_DEMUX_BROADCAST_EN adds in_bcast, a per-beat all-lane broadcast flag.
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int DEPTH = 2,
  localparam int SEL_W = $clog2(N_OUT),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
`ifdef STREAM_DEMUX_BROADCAST_EN
  input  logic             in_bcast,
`endif
  output logic [N_OUT-1:0] out_valid,
  input  logic [N_OUT-1:0] out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       drop_cnt
);

  logic [WIDTH-1:0] r_mem_data [DEPTH];
  logic [SEL_W-1:0] r_mem_sel  [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             r_in_ready;
  logic [7:0]       r_drop;

  logic             w_empty;
  logic             w_acc;
  logic             w_keep;
  logic             w_sel_ok;
  logic             w_push;
  logic             w_pop;
  logic             w_head_bc;
  logic [SEL_W-1:0] w_head_sel;
  logic [N_OUT-1:0] w_lanes;
  logic [AW:0]      w_wptr_n;
  logic [AW:0]      w_rptr_n;
  logic             w_full_n;

  // Power-of-two lane counts cannot see an out-of-range select.
  if (N_OUT == (1 << SEL_W)) begin : g_sel_pow2
    assign w_sel_ok = 1'b1;
  end else begin : g_sel_chk
    assign w_sel_ok = (32'(in_sel) < N_OUT);
  end

`ifdef STREAM_DEMUX_BROADCAST_EN
  logic r_mem_bc [DEPTH];
  assign w_keep    = in_bcast || w_sel_ok;
  assign w_head_bc = r_mem_bc[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_mem_bc[r_wptr[AW-1:0]] <= in_bcast;
  end
`else
  assign w_keep    = w_sel_ok;
  assign w_head_bc = 1'b0;
`endif

  assign w_empty    = (r_wptr == r_rptr);
  assign w_acc      = in_valid && r_in_ready;
  assign w_push     = w_acc && w_keep;
  assign w_head_sel = r_mem_sel[r_rptr[AW-1:0]];

  always_comb begin
    w_lanes = '0;
    for (int i = 0; i < N_OUT; i++) begin
      w_lanes[i] = w_head_bc || (w_head_sel == SEL_W'(i));
    end
  end

  // Broadcast needs every lane ready; a single-lane head needs only its own.
  assign w_pop = !w_empty &&
                 (w_head_bc ? (&out_ready) : (|(w_lanes & out_ready)));

  assign w_wptr_n = r_wptr + (AW+1)'(w_push);
  assign w_rptr_n = r_rptr + (AW+1)'(w_pop);
  assign w_full_n = (w_wptr_n[AW] != w_rptr_n[AW]) &&
                    (w_wptr_n[AW-1:0] == w_rptr_n[AW-1:0]);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr[AW-1:0]] <= in_data;
      r_mem_sel[r_wptr[AW-1:0]]  <= in_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_in_ready <= 1'b0;
      r_drop     <= '0;
    end else begin
      r_wptr     <= w_wptr_n;
      r_rptr     <= w_rptr_n;
      r_in_ready <= !w_full_n;
      if (w_acc && !w_keep && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_empty ? '0 : w_lanes;
  assign out_data  = w_empty ? '0 : r_mem_data[r_rptr[AW-1:0]];
  assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed checks of stream_demux (4-lane main instance,
// 3-lane instance for out-of-range selects).
module tb_stream_demux;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic [7:0] drop_cnt;

  logic       v1;
  logic       rdy1;
  logic [7:0] d1;
  logic [1:0] s1;
  logic [2:0] ov1;
  logic [2:0] or1;
  logic [7:0] od1;
  logic [7:0] dc1;

`ifdef STREAM_DEMUX_BROADCAST_EN
  logic bc0;
  logic bc1;
`endif

  int n_vec;
  int n_err;

  stream_demux #(.WIDTH(8), .N_OUT(4), .DEPTH(2)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel),
`ifdef STREAM_DEMUX_BROADCAST_EN
    .in_bcast(bc0),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .drop_cnt(drop_cnt)
  );

  stream_demux #(.WIDTH(8), .N_OUT(3), .DEPTH(2)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v1), .in_ready(rdy1),
    .in_data(d1), .in_sel(s1),
`ifdef STREAM_DEMUX_BROADCAST_EN
    .in_bcast(bc1),
`endif
    .out_valid(ov1), .out_ready(or1),
    .out_data(od1), .drop_cnt(dc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_vec++;
    if (out_valid !== 4'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out: valid=%b ready=%b want 0000/0",
               out_valid, in_ready);
    end
    n_vec++;
    if (out_data !== 8'h00 || drop_cnt !== 8'h00) begin
      n_err++;
      $display("FAIL reset_data: data=%h drop=%h want 00/00",
               out_data, drop_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || rdy1 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_rel: ready=%b/%b want 1/1", in_ready, rdy1);
    end
  endtask

  task automatic test_single();
    out_ready = 4'hF;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hA5; in_sel = 2'd2;
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 4'b0100 || out_data !== 8'hA5) begin
      n_err++;
      $display("FAIL single: valid=%b data=%h want 0100/a5",
               out_valid, out_data);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 4'b0000) begin
      n_err++;
      $display("FAIL single_once: valid=%b want 0000", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ev;
    out_ready = 4'hF;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        ev = 4'b0001 << ((i - 1) % 4);
        n_vec++;
        if (out_valid !== ev || out_data !== 8'(i - 1)) begin
          n_err++;
          $display("FAIL b2b[%0d]: valid=%b data=%h want %b/%h",
                   i - 1, out_valid, out_data, ev, 8'(i - 1));
        end
      end
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready[%0d]: ready=%b want 1", i, in_ready);
      end
      if (i < 8) begin
        in_valid = 1'b1; in_data = 8'(i); in_sel = 2'(i % 4);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 4'b0000) begin
      n_err++;
      $display("FAIL b2b_end: valid=%b want 0000", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1101;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h10; in_sel = 2'd1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_one: ready=%b want 1", in_ready);
    end
    in_data = 8'h11;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 4'b0010 || out_data !== 8'h10) begin
      n_err++;
      $display("FAIL bp_full: ready=%b valid=%b data=%h want 0/0010/10",
               in_ready, out_valid, out_data);
    end
    in_data = 8'h12;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 4'b0010 || out_data !== 8'h10) begin
      n_err++;
      $display("FAIL bp_hold: ready=%b valid=%b data=%h want 0/0010/10",
               in_ready, out_valid, out_data);
    end
    out_ready = 4'hF;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_data !== 8'h11) begin
      n_err++;
      $display("FAIL bp_drain1: ready=%b data=%h want 1/11",
               in_ready, out_data);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 4'b0010 || out_data !== 8'h12) begin
      n_err++;
      $display("FAIL bp_third: valid=%b data=%h want 0010/12",
               out_valid, out_data);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 4'b0000) begin
      n_err++;
      $display("FAIL bp_empty: valid=%b want 0000", out_valid);
    end
  endtask

  task automatic test_head_of_line();
    out_ready = 4'b1000;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h20; in_sel = 2'd0;
    @(negedge clk);
    in_data = 8'h23; in_sel = 2'd3;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (out_valid !== 4'b0001 || out_data !== 8'h20) begin
        n_err++;
        $display("FAIL hol_block[%0d]: valid=%b data=%h want 0001/20",
                 k, out_valid, out_data);
      end
      @(negedge clk);
    end
    out_ready = 4'hF;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 4'b1000 || out_data !== 8'h23) begin
      n_err++;
      $display("FAIL hol_next: valid=%b data=%h want 1000/23",
               out_valid, out_data);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 4'b0000) begin
      n_err++;
      $display("FAIL hol_empty: valid=%b want 0000", out_valid);
    end
  endtask

  task automatic test_invalid_sel();
    int bad;
    bad = 0;
    or1 = 3'b111;
    @(negedge clk);
    v1 = 1'b1; d1 = 8'h55; s1 = 2'd3;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (ov1 !== 3'b000 || rdy1 !== 1'b1) bad++;
      if (i == 10) begin
        n_vec++;
        if (dc1 !== 8'd10) begin
          n_err++;
          $display("FAIL drop_mid: drop=%0d want 10", dc1);
        end
      end
    end
    v1 = 1'b0;
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL drop_accept: %0d bad cycles want 0", bad);
    end
    n_vec++;
    if (dc1 !== 8'd255) begin
      n_err++;
      $display("FAIL drop_sat: drop=%0d want 255", dc1);
    end
    v1 = 1'b1; d1 = 8'h3C; s1 = 2'd2;
    @(negedge clk);
    v1 = 1'b0;
    n_vec++;
    if (ov1 !== 3'b100 || od1 !== 8'h3C || dc1 !== 8'd255) begin
      n_err++;
      $display("FAIL n3_lane2: valid=%b data=%h drop=%0d want 100/3c/255",
               ov1, od1, dc1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    out_ready = 4'b0000;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h77; in_sel = 2'd1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 4'b0010) begin
      n_err++;
      $display("FAIL rm_full: ready=%b valid=%b want 0/0010",
               in_ready, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 4'b0000 || dc1 !== 8'd0) begin
      n_err++;
      $display("FAIL rm_async: ready=%b valid=%b drop=%0d want 0/0000/0",
               in_ready, out_valid, dc1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 4'b0000 || dc1 !== 8'd0) begin
      n_err++;
      $display("FAIL rm_after: ready=%b valid=%b drop=%0d want 1/0000/0",
               in_ready, out_valid, dc1);
    end
  endtask

`ifdef STREAM_DEMUX_BROADCAST_EN
  task automatic test_broadcast();
    out_ready = 4'b0111;
    @(negedge clk);
    in_valid = 1'b1; bc0 = 1'b1; in_data = 8'hBC; in_sel = 2'd0;
    @(negedge clk);
    in_valid = 1'b0; bc0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (out_valid !== 4'b1111 || out_data !== 8'hBC) begin
        n_err++;
        $display("FAIL bc_wait[%0d]: valid=%b data=%h want 1111/bc",
                 k, out_valid, out_data);
      end
      @(negedge clk);
    end
    out_ready = 4'hF;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 4'b0000) begin
      n_err++;
      $display("FAIL bc_pop: valid=%b want 0000", out_valid);
    end
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;
    v1 = 1'b0; d1 = '0; s1 = '0; or1 = 3'b111;
`ifdef STREAM_DEMUX_BROADCAST_EN
    bc0 = 1'b0; bc1 = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_head_of_line();
    test_invalid_sel();
    test_reset_mid();
`ifdef STREAM_DEMUX_BROADCAST_EN
    test_broadcast();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
